// File: rtl/instruction_decode.sv
// instruction_decode
//   Decode stage sitting right after the instruction fetcher. Takes opcode
//   bytes over the DIR/ack_prev handshake and joins LDI with its immediate
//   byte. Splits the instruction into fields and reads operands from a 4x8
//   register file, which has a writeback port with read bypass. The decoded
//   bundle goes to execute over the DOR/ack_from_next handshake.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   DIR, data_in        upstream byte valid (held until acked) and byte
//   ack_prev            one-cycle registered accept pulse to upstream
//   DOR, ack_from_next  decoded bundle valid (held) and downstream accept
//   op_out, dst_out     instr[7:4], instr[3:2]
//   a_out, b_out        rf[dst]; rf[src], or the immediate for LDI
//   illegal             op_out == ILL_OP (forwarded, not trapped)
//   wb_en/addr/data     register file write port
module instruction_decode #(
  parameter logic [3:0] LDI_OP = 4'hF,
  parameter logic [3:0] ILL_OP = 4'hE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DIR,
  output logic       ack_prev,
  input  logic [7:0] data_in,
  output logic       DOR,
  input  logic       ack_from_next,
  output logic [3:0] op_out,
  output logic [1:0] dst_out,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic       illegal,
  input  logic       wb_en,
  input  logic [1:0] wb_addr,
  input  logic [7:0] wb_data
);

  typedef enum logic [1:0] {IDLE, WAIT_IMM, DECODE, WAIT_NEXT} state_t;

  state_t     state, state_nxt;
  logic       armed;
  logic [7:0] ir, imm;
  logic [7:0] rf [4];
  logic [7:0] rd_a, rd_b;
  logic       accept, load_ir, load_imm, load_out, release_out;

  // ---------------- state register ----------------
  // NOTE: every clocked process uses non-blocking assignments, so all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  // NOTE: each combinational process assigns its outputs a default first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = (data_in[7:4] == LDI_OP) ? WAIT_IMM : DECODE;
      WAIT_IMM:  if (accept) state_nxt = DECODE;
      DECODE:    state_nxt = WAIT_NEXT;
      WAIT_NEXT: if (ack_from_next) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // ---------------- output / control decode ----------------
  // A byte counts only when armed. This stops a byte from being taken twice
  // while upstream still holds DIR in the cycle after our ack.
  always_comb begin
    accept      = 1'b0;
    load_ir     = 1'b0;
    load_imm    = 1'b0;
    load_out    = 1'b0;
    release_out = 1'b0;
    unique case (state)
      IDLE: begin
        accept  = DIR && armed;
        load_ir = accept;
      end
      WAIT_IMM: begin
        accept   = DIR && armed;
        load_imm = accept;
      end
      DECODE:    load_out    = 1'b1;
      WAIT_NEXT: release_out = ack_from_next;
      default: ;
    endcase
  end

  // ---------------- register file with write-through bypass ----------------
  // NOTE: the register file is reset explicitly, because it must read as
  // zero after reset. This is cheap at 4x8.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // A write landing in the DECODE cycle must be seen by that decode.
  assign rd_a = (wb_en && wb_addr == ir[3:2]) ? wb_data : rf[ir[3:2]];
  assign rd_b = (wb_en && wb_addr == ir[1:0]) ? wb_data : rf[ir[1:0]];

  // ---------------- handshake and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      armed    <= 1'b1;
      ack_prev <= 1'b0;
      ir       <= '0;
      imm      <= '0;
      DOR      <= 1'b0;
      op_out   <= '0;
      dst_out  <= '0;
      a_out    <= '0;
      b_out    <= '0;
      illegal  <= 1'b0;
    end else begin
      ack_prev <= accept;
      if (accept)   armed <= 1'b0;
      else if (!DIR) armed <= 1'b1;

      if (load_ir)  ir  <= data_in;
      if (load_imm) imm <= data_in;

      // The fields are loaded only in DECODE. They then stay frozen for as
      // long as DOR is held, so later register writes do not show up.
      if (load_out) begin
        DOR     <= 1'b1;
        op_out  <= ir[7:4];
        dst_out <= ir[3:2];
        illegal <= (ir[7:4] == ILL_OP);
        a_out   <= rd_a;
        b_out   <= (ir[7:4] == LDI_OP) ? imm : rd_b;
      end else if (release_out) begin
        DOR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       DIR;
  logic       ack_prev;
  logic [7:0] data_in;
  logic       DOR;
  logic       ack_from_next;
  logic [3:0] op_out;
  logic [1:0] dst_out;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic       illegal;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit wb_rand = 0;

  // Reference register contents after each clock edge.
  logic [7:0] model_rf [4];

  instruction_decode dut (
    .clk(clk), .reset(reset), .DIR(DIR), .ack_prev(ack_prev), .data_in(data_in),
    .DOR(DOR), .ack_from_next(ack_from_next), .op_out(op_out), .dst_out(dst_out),
    .a_out(a_out), .b_out(b_out), .illegal(illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
    else if (wb_en) model_rf[wb_addr] = wb_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; optionally randomise the write port.
  task automatic step();
    @(negedge clk);
    if (wb_rand) begin
      wb_en   = 1'($urandom_range(0, 1));
      wb_addr = 2'($urandom_range(0, 3));
      wb_data = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_prev) return;
    end
    check("ack_timeout", 0, 1);
  endtask

  task automatic wait_dor();
    for (int i = 0; i < 20; i++) begin
      if (DOR) return;
      step();
    end
    check("dor_timeout", 0, 1);
  endtask

  // Present one byte and wait for its ack. Then drop DIR for one cycle, so
  // the decoder is armed for the next byte.
  task automatic send_byte(input logic [7:0] b);
    DIR = 1'b1;
    data_in = b;
    wait_ack();
    DIR = 1'b0;
    step();
    check("ack_single", ack_prev, 0);
  endtask

  task automatic finish_bundle();
    ack_from_next = 1'b1;
    step();
    ack_from_next = 1'b0;
    check("dor_drop", DOR, 0);
  endtask

  task automatic check_bundle(input logic [3:0] op, input logic [1:0] dst,
                              input logic [7:0] a, input logic [7:0] b, input logic ill);
    check("dor", DOR, 1);
    check("op_out", op_out, op);
    check("dst_out", dst_out, dst);
    check("a_out", a_out, a);
    check("b_out", b_out, b);
    check("illegal", illegal, ill);
  endtask

  initial begin
    int acks, dors;
    logic [3:0] s_op; logic [1:0] s_dst; logic [7:0] s_a, s_b;
    reset = 1'b1; DIR = 1'b0; data_in = '0; ack_from_next = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    step(); step();

    // Reset state
    check("rst_dor", DOR, 0);
    check("rst_ack", ack_prev, 0);
    check("rst_fields", {op_out, dst_out, a_out, b_out, illegal}, 0);
    reset = 1'b0;
    step();

    // Simple instruction with DIR held for 3 cycles
    wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h22; step();
    wb_addr = 2'd2; wb_data = 8'h33; step();
    wb_en = 1'b0;
    DIR = 1'b1; data_in = 8'h36; acks = 0;
    repeat (3) begin step(); acks += int'(ack_prev); end
    DIR = 1'b0;
    check_bundle(4'h3, 2'd1, 8'h22, 8'h33, 1'b0);
    finish_bundle();
    dors = 0;
    repeat (3) begin step(); acks += int'(ack_prev); dors += int'(DOR); end
    check("hold_acks", acks, 1);
    check("hold_extra_dor", dors, 0);

    // LDI with a 4-cycle gap before the immediate
    send_byte(8'hF8);
    repeat (4) begin step(); check("ldi_gap_dor", DOR, 0); check("ldi_gap_ack", ack_prev, 0); end
    send_byte(8'h5A);
    check("ldi_dor_lat", DOR, 1);
    check_bundle(4'hF, 2'd2, 8'h33, 8'h5A, 1'b0);
    finish_bundle();

    // Backpressure: a new byte waits while the bundle is held
    send_byte(8'h46);
    wait_dor();
    s_op = op_out; s_dst = dst_out; s_a = a_out; s_b = b_out;
    check_bundle(4'h4, 2'd1, 8'h22, 8'h33, 1'b0);
    DIR = 1'b1; data_in = 8'h20;
    repeat (10) begin
      step();
      check("bp_dor", DOR, 1);
      check("bp_fields", {op_out, dst_out, a_out, b_out}, {s_op, s_dst, s_a, s_b});
      check("bp_no_ack", ack_prev, 0);
    end
    ack_from_next = 1'b1; step(); ack_from_next = 1'b0;
    check("bp_dor_drop", DOR, 0);
    check("bp_ack_early", ack_prev, 0);
    step();
    check("bp_pending_ack", ack_prev, 1);
    DIR = 1'b0;
    step();
    wait_dor();
    check_bundle(4'h2, 2'd0, 8'h00, 8'h00, 1'b0);
    finish_bundle();

    // Bypass: a write in the DECODE cycle
    DIR = 1'b1; data_in = 8'h10;
    wait_ack();
    DIR = 1'b0; wb_en = 1'b1; wb_addr = 2'd0; wb_data = 8'h7E;
    step();
    wb_en = 1'b0;
    check_bundle(4'h1, 2'd0, 8'h7E, 8'h7E, 1'b0);
    finish_bundle();

    // Illegal opcode forwarded, then cleared
    send_byte(8'hE5);
    wait_dor();
    check_bundle(4'hE, 2'd1, 8'h22, 8'h22, 1'b1);
    finish_bundle();
    send_byte(8'h00);
    wait_dor();
    check_bundle(4'h0, 2'd0, 8'h7E, 8'h7E, 1'b0);
    finish_bundle();

    // Reset while waiting for the LDI immediate
    send_byte(8'hF4);
    reset = 1'b1; step();
    check("rst_mid_dor", DOR, 0);
    check("rst_mid_fields", {op_out, dst_out, a_out, b_out, illegal}, 0);
    reset = 1'b0; step();
    check("rst_rel_dor", DOR, 0);
    check("rst_rel_ack", ack_prev, 0);
    send_byte(8'h21);
    check("rst_single_lat", DOR, 1);
    check_bundle(4'h2, 2'd0, 8'h00, 8'h00, 1'b0);
    finish_bundle();

    // Random instructions; the register file is written in every cycle
    wb_rand = 1;
    for (int n = 0; n < 40; n++) begin
      logic [3:0] op; logic [1:0] dst, src; logic [7:0] imm, ea, eb;
      int sel;
      sel = int'($urandom_range(0, 5));
      op  = (sel == 0) ? 4'hF : (sel == 1) ? 4'hE : 4'($urandom_range(0, 15));
      dst = 2'($urandom_range(0, 3));
      src = 2'($urandom_range(0, 3));
      imm = 8'($urandom_range(0, 255));
      send_byte({op, dst, src});
      if (op == 4'hF) begin
        repeat ($urandom_range(0, 3)) begin step(); check("r_gap_dor", DOR, 0); end
        check("r_wait_dor", DOR, 0);
        send_byte(imm);
      end
      check("r_dor_lat", DOR, 1);
      wait_dor();
      // DOR rose at the last edge; writes up to and including the decode
      // cycle count, and a write in that cycle is bypassed in.
      ea = model_rf[dst];
      eb = (op == 4'hF) ? imm : model_rf[src];
      check_bundle(op, dst, ea, eb, op == 4'hE);
      repeat ($urandom_range(0, 3)) begin
        step();
        check("r_hold", {DOR, a_out, b_out}, {1'b1, ea, eb});
      end
      finish_bundle();
    end
    wb_rand = 0;
    wb_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
